centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
- Downstream consumer of the per-frame blob centroid stage.
- Takes one (X,Y) centroid pulse per frame and applies confirmation, gating and an exponential moving-average filter.
- Runs a lock/lost state machine and presents filtered positions on a valid/ready report interface to the game/cursor logic.
- Input (0,0) means "no target this frame".

Parameters:
- W, 11, coordinate width.
- GATE, 32, max per-axis distance (pixels) for a sample to count as a hit.
- CONFIRM_FRAMES, 3, consecutive gated hits required to lock.
- LOST_FRAMES, 8, consecutive misses that drop lock.
- ALPHA_SHIFT, 2, EMA weight 1/2^ALPHA_SHIFT.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-low.
- iX  in  W  centroid X from the upstream stage.
- iY  in  W  centroid Y from the upstream stage.
- iDVAL  in  1  one-cycle centroid-valid pulse, normally once per frame.
- oX  out  W  filtered X of the current report.
- oY  out  W  filtered Y of the current report.
- oVALID  out  1  report available.
- iREADY  in  1  consumer accepts the report.
- oLOCKED  out  1  FSM is in TRACK or COAST.
- oDROP_CNT  out  8  saturating count of overwritten reports.

Behaviour:
- Reset (iRST low, async): state SEARCH; filter, candidate and counters cleared; oX=oY=0, oVALID=0, oLOCKED=0, oDROP_CNT=0.
- Empty sample: iX==0 && iY==0.
- Hit: non-empty and |iX-ref|<=GATE and |iY-ref|<=GATE. The difference is computed signed at W+1 bits. ref is the candidate in ACQUIRE and the filter in TRACK/COAST.
- Pipeline:
  - iDVAL high in cycle c: FSM and filter update at the end of c.
  - Report register loads at the end of c+1; oVALID is high from c+2.
  - Back-to-back iDVAL pulses are each processed; there is no stall.
- FSM:
  - SEARCH: non-empty -> candidate=sample, conf=1, go ACQUIRE. Empty -> stay.
  - ACQUIRE:
    - Hit -> candidate=sample, conf++. When conf reaches CONFIRM_FRAMES -> TRACK, filter=sample.
    - Non-empty miss -> candidate=sample, conf=1.
    - Empty -> SEARCH.
  - TRACK: hit -> filter update. Empty or out-of-gate -> COAST, miss=1, filter held.
  - COAST:
    - Hit -> TRACK, miss=0, filter update.
    - Otherwise miss++. When miss reaches LOST_FRAMES -> SEARCH, filter held but unused.
- Filter update: f = f + ((s - f) >>> ALPHA_SHIFT).
  - Signed W+1-bit difference; arithmetic shift, which rounds toward -inf.
  - Result is truncated to W bits and always lies between f and s, so no clamp is needed.
- Report generation: one report per processed iDVAL whose post-update state is TRACK or COAST. The report content is the post-update filter.
  - No report from SEARCH or ACQUIRE.
  - No report on the transition to SEARCH.
- oLOCKED is registered with the FSM and high in TRACK/COAST.
- Report register:
  - Loaded while oVALID=0: load, oVALID=1.
  - oVALID && iREADY with no new report: oVALID=0.
  - oVALID && iREADY with a new report in the same cycle: load the new report, oVALID stays 1, no drop.
  - oVALID && !iREADY with a new report: overwrite with the newest, oDROP_CNT++ saturating at 255.
  - oX/oY are stable while oVALID && !iREADY unless overwritten.
- Reset mid-operation: everything returns to reset values immediately; a pending report is lost.

Optional Feature:
- Macro: CENTROID_VELOCITY_EN.
- Defined:
  - Adds outputs oVX and oVY, W+1 bits signed, equal to the filter minus the filter of the previous report. Loaded with each report.
  - Velocity is 0 on the first report after entering TRACK from ACQUIRE.
  - Reset value is 0.
- Undefined: the ports and the previous-filter registers are absent; all other behaviour is identical.

Decomposition:
- Package centroid_pkg:
  - W default constant.
  - State enum: SEARCH, ACQUIRE, TRACK, COAST.
  - Packed report struct {x, y[, vx, vy]}.
  - Gate-compare function.
- Sub-module centroid_report_reg: valid/ready holding register with overwrite and the saturating drop counter.

Test Plan:
- Reset: assert iRST low mid-frame -> all outputs 0 and state SEARCH within the same cycle (asynchronous).
- Acquire: pulses (100,200), (102,201), (104,203) -> oLOCKED=1 after the third; oVALID 2 cycles later with (104,203); no reports before the third.
- EMA: locked at (104,203), sample (120,203) -> report (108,203). Sample (100,203) -> 108+(-8>>>2)=106, report (106,203).
- Outlier/coast:
  - From TRACK at (106,203), sample (300,203) -> COAST, report (106,203).
  - Then (110,205) -> TRACK, report (107,203).
- Lost: 8 consecutive empty pulses from TRACK -> 7 reports; oLOCKED falls after the 8th; no 8th report.
- Backpressure: iREADY=0 across two reports -> oDROP_CNT=1, oX/oY hold the second. iREADY=1 in the same cycle as a third report -> oVALID stays 1, no drop.

Source files
------------

// File: rtl/centroid_pkg.sv
// Shared types and helpers for the centroid tracker.
// Optional velocity fields are present when CENTROID_VELOCITY_EN is defined.
package centroid_pkg;

    localparam int DEF_W  = 11;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        TRACK,
        COAST
    } state_t;

    typedef struct packed {
        logic [DEF_W-1:0]        x;
        logic [DEF_W-1:0]        y;
`ifdef CENTROID_VELOCITY_EN
        logic signed [DEF_W:0]   vx;
        logic signed [DEF_W:0]   vy;
`endif
    } report_t;

    // diff is the sign-extended W+1 bit difference between sample and reference
    function automatic logic inGate(input int diff, input int gate);
        return (diff <= gate) && (diff >= -gate);
    endfunction

endpackage

// File: rtl/centroid_tracker_if.sv
// Sample input and report output channels of the centroid tracker.
// Velocity signals are present when CENTROID_VELOCITY_EN is defined.
interface centroid_tracker_if #(parameter int W = centroid_pkg::DEF_W);

    logic [W-1:0]        iX;
    logic [W-1:0]        iY;
    logic                iDVAL;
    logic [W-1:0]        oX;
    logic [W-1:0]        oY;
    logic                oVALID;
    logic                iREADY;
`ifdef CENTROID_VELOCITY_EN
    logic signed [W:0]   oVX;
    logic signed [W:0]   oVY;

    modport slave  (input  iX, iY, iDVAL, iREADY,
                    output oX, oY, oVALID, oVX, oVY);
    modport master (output iX, iY, iDVAL, iREADY,
                    input  oX, oY, oVALID, oVX, oVY);
`else
    modport slave  (input  iX, iY, iDVAL, iREADY,
                    output oX, oY, oVALID);
    modport master (output iX, iY, iDVAL, iREADY,
                    input  oX, oY, oVALID);
`endif

endinterface

// File: rtl/centroid_report_reg.sv
// Valid/ready report holding register: newest report always wins, and every
// report overwritten before acceptance bumps a saturating drop counter.
module centroid_report_reg
    import centroid_pkg::*;
#(
    parameter type rpt_t = report_t
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iLOAD,
    input  rpt_t              iDATA,
    input  logic              iREADY,
    output rpt_t              oDATA,
    output logic              oVALID,
    output logic [DROP_W-1:0] oDROP_CNT
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA     <= '0;
            oVALID    <= 1'b0;
            oDROP_CNT <= '0;
        end else if (iLOAD) begin
            oDATA  <= iDATA;
            oVALID <= 1'b1;
            if (oVALID && !iREADY && (oDROP_CNT != DROP_MAX))
                oDROP_CNT <= oDROP_CNT + DROP_ONE;
        end else if (oVALID && iREADY) begin
            oVALID <= 1'b0;
        end
    end

endmodule

// File: rtl/centroid_tracker.sv
// Centroid tracker: confirm/gate incoming centroids, EMA-filter while locked,
// and emit filtered reports. Define CENTROID_VELOCITY_EN to add oVX/oVY.
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int W              = DEF_W,
    parameter int GATE           = 32,
    parameter int CONFIRM_FRAMES = 3,
    parameter int LOST_FRAMES    = 8,
    parameter int ALPHA_SHIFT    = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    centroid_tracker_if.slave bus,
    output logic              oLOCKED,
    output logic [DROP_W-1:0] oDROP_CNT
);

    localparam int CNT_MAX = (CONFIRM_FRAMES > LOST_FRAMES) ? CONFIRM_FRAMES : LOST_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_FRAMES - 1);
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(LOST_FRAMES - 1);

    typedef struct packed {
        logic [W-1:0]        x;
        logic [W-1:0]        y;
`ifdef CENTROID_VELOCITY_EN
        logic signed [W:0]   vx;
        logic signed [W:0]   vy;
`endif
    } rpt_t;

    // f + ((s - f) >>> ALPHA_SHIFT); the floor shift keeps the result between f and s
    function automatic logic [W-1:0] emaStep(input logic [W-1:0] f, input logic [W-1:0] s);
        logic signed [W:0] d;
        logic signed [W:0] step;
        d    = $signed({1'b0, s}) - $signed({1'b0, f});
        step = d >>> ALPHA_SHIFT;
        return f + step[W-1:0];
    endfunction

    state_t            state_p0;
    logic [W-1:0]      candX_p0, candY_p0;
    logic [W-1:0]      filtX_p0, filtY_p0;
    logic [CNT_W-1:0]  conf_p0, miss_p0;
    logic              locked_p0;
    logic              rptVld_p1;

    logic              empty, hit;
    logic [W-1:0]      refX, refY;
    logic signed [W:0] dX, dY;
    logic [W-1:0]      emaX, emaY;

    assign empty = (bus.iX == '0) && (bus.iY == '0);
    assign refX  = (state_p0 == ACQUIRE) ? candX_p0 : filtX_p0;
    assign refY  = (state_p0 == ACQUIRE) ? candY_p0 : filtY_p0;
    assign dX    = $signed({1'b0, bus.iX}) - $signed({1'b0, refX});
    assign dY    = $signed({1'b0, bus.iY}) - $signed({1'b0, refY});
    assign hit   = !empty && inGate(int'(dX), GATE) && inGate(int'(dY), GATE);
    assign emaX  = emaStep(filtX_p0, bus.iX);
    assign emaY  = emaStep(filtY_p0, bus.iY);

`ifdef CENTROID_VELOCITY_EN
    logic         firstRpt_p1;
    logic [W-1:0] prevX_p1, prevY_p1;
`endif

    // Stage p0: state, candidate and filter update on each centroid pulse
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_p0    <= SEARCH;
            candX_p0    <= '0;
            candY_p0    <= '0;
            filtX_p0    <= '0;
            filtY_p0    <= '0;
            conf_p0     <= '0;
            miss_p0     <= '0;
            locked_p0   <= 1'b0;
            rptVld_p1   <= 1'b0;
`ifdef CENTROID_VELOCITY_EN
            firstRpt_p1 <= 1'b0;
`endif
        end else begin
            rptVld_p1   <= 1'b0;
`ifdef CENTROID_VELOCITY_EN
            firstRpt_p1 <= 1'b0;
`endif
            if (bus.iDVAL) begin
                case (state_p0)
                    SEARCH: begin
                        if (!empty) begin
                            candX_p0 <= bus.iX;
                            candY_p0 <= bus.iY;
                            conf_p0  <= CNT_ONE;
                            state_p0 <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (empty) begin
                            state_p0 <= SEARCH;
                        end else begin
                            candX_p0 <= bus.iX;
                            candY_p0 <= bus.iY;
                            if (!hit) begin
                                conf_p0 <= CNT_ONE;
                            end else if (conf_p0 == CONF_LAST) begin
                                state_p0    <= TRACK;
                                locked_p0   <= 1'b1;
                                filtX_p0    <= bus.iX;
                                filtY_p0    <= bus.iY;
                                rptVld_p1   <= 1'b1;
`ifdef CENTROID_VELOCITY_EN
                                firstRpt_p1 <= 1'b1;
`endif
                            end else begin
                                conf_p0 <= conf_p0 + CNT_ONE;
                            end
                        end
                    end
                    TRACK: begin
                        rptVld_p1 <= 1'b1;
                        if (hit) begin
                            filtX_p0 <= emaX;
                            filtY_p0 <= emaY;
                        end else begin
                            state_p0 <= COAST;
                            miss_p0  <= CNT_ONE;
                        end
                    end
                    COAST: begin
                        if (hit) begin
                            state_p0  <= TRACK;
                            miss_p0   <= '0;
                            filtX_p0  <= emaX;
                            filtY_p0  <= emaY;
                            rptVld_p1 <= 1'b1;
                        end else if (miss_p0 == MISS_LAST) begin
                            state_p0  <= SEARCH;
                            locked_p0 <= 1'b0;
                        end else begin
                            miss_p0   <= miss_p0 + CNT_ONE;
                            rptVld_p1 <= 1'b1;
                        end
                    end
                    default: begin
                        state_p0  <= SEARCH;
                        locked_p0 <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oLOCKED = locked_p0;

    // Stage p1: assemble the report from the post-update filter
    rpt_t rptData_p1;
    rpt_t rptOut_p2;

`ifdef CENTROID_VELOCITY_EN
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            prevX_p1 <= '0;
            prevY_p1 <= '0;
        end else if (rptVld_p1) begin
            prevX_p1 <= filtX_p0;
            prevY_p1 <= filtY_p0;
        end
    end
`endif

    always_comb begin
        rptData_p1   = '0;
        rptData_p1.x = filtX_p0;
        rptData_p1.y = filtY_p0;
`ifdef CENTROID_VELOCITY_EN
        if (!firstRpt_p1) begin
            rptData_p1.vx = $signed({1'b0, filtX_p0}) - $signed({1'b0, prevX_p1});
            rptData_p1.vy = $signed({1'b0, filtY_p0}) - $signed({1'b0, prevY_p1});
        end
`endif
    end

    // Stage p2: report holding register
    centroid_report_reg #(.rpt_t(rpt_t)) uReport (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iLOAD     (rptVld_p1),
        .iDATA     (rptData_p1),
        .iREADY    (bus.iREADY),
        .oDATA     (rptOut_p2),
        .oVALID    (bus.oVALID),
        .oDROP_CNT (oDROP_CNT)
    );

    assign bus.oX = rptOut_p2.x;
    assign bus.oY = rptOut_p2.y;
`ifdef CENTROID_VELOCITY_EN
    assign bus.oVX = rptOut_p2.vx;
    assign bus.oVY = rptOut_p2.vy;
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// Bench for centroid_tracker: directed vector table, hand sequences for
// backpressure / async reset / drop saturation, and a randomized model run.
module tb_centroid_tracker;

    localparam int W     = 11;
    localparam int GATE  = 32;
    localparam int CONF  = 3;
    localparam int LOST  = 8;
    localparam int DIV   = 4;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       oLOCKED;
    logic [7:0] oDROP_CNT;

    centroid_tracker_if #(.W(W)) bus ();

    centroid_tracker #(.W(W), .GATE(GATE), .CONFIRM_FRAMES(CONF),
                       .LOST_FRAMES(LOST), .ALPHA_SHIFT(2)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .bus       (bus),
        .oLOCKED   (oLOCKED),
        .oDROP_CNT (oDROP_CNT)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: tracks lock status by counting streaks and misses
    typedef struct { int x; int y; } pt_t;
    pt_t expQ[$];
    int  mStreak, mMiss, mCx, mCy, mFx, mFy;
    bit  mLocked;

    function automatic bit near(int a, int b);
        return (a - b <= GATE) && (b - a <= GATE);
    endfunction

    function automatic int floorDiv(int d);
        return (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);
    endfunction

    task automatic modelReset();
        mStreak = 0; mMiss = 0; mLocked = 0;
        mCx = 0; mCy = 0; mFx = 0; mFy = 0;
        expQ.delete();
    endtask

    task automatic modelPulse(input int x, input int y);
        bit isEmpty;
        isEmpty = (x == 0) && (y == 0);
        if (!mLocked) begin
            if (isEmpty) begin
                mStreak = 0;
            end else if (mStreak > 0 && near(x, mCx) && near(y, mCy)) begin
                mStreak++;
                mCx = x; mCy = y;
                if (mStreak >= CONF) begin
                    mLocked = 1; mMiss = 0; mFx = x; mFy = y;
                    expQ.push_back('{mFx, mFy});
                end
            end else begin
                mStreak = 1; mCx = x; mCy = y;
            end
        end else if (!isEmpty && near(x, mFx) && near(y, mFy)) begin
            mMiss = 0;
            mFx = mFx + floorDiv(x - mFx);
            mFy = mFy + floorDiv(y - mFy);
            expQ.push_back('{mFx, mFy});
        end else begin
            mMiss++;
            if (mMiss >= LOST) begin
                mLocked = 0; mStreak = 0;
            end else begin
                expQ.push_back('{mFx, mFy});
            end
        end
    endtask

    // Every cycle with oVALID && iREADY is one accepted report
    bit monEn = 0;
    always @(negedge iCLK) begin
        if (monEn && bus.oVALID && bus.iREADY) begin
            if (expQ.size() == 0) begin
                chk("rpt_unexpected", 1, 0);
            end else begin
                pt_t e;
                e = expQ.pop_front();
                chk("rpt_x", int'(bus.oX), e.x);
                chk("rpt_y", int'(bus.oY), e.y);
            end
        end
    end

    // Pulse in one cycle; returns #1 after the edge that consumed it
    task automatic pulse(input int x, input int y);
        @(negedge iCLK);
        bus.iX    = x[W-1:0];
        bus.iY    = y[W-1:0];
        bus.iDVAL = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iDVAL = 1'b0;
    endtask

    typedef struct { int x; int y; bit lk; bit rv; int ex; int ey; } vec_t;
    vec_t tbl[18];

    initial begin
        bus.iX = '0; bus.iY = '0; bus.iDVAL = 1'b0; bus.iREADY = 1'b1;

        tbl[0] = '{100, 200, 0, 0,   0,   0};
        tbl[1] = '{102, 201, 0, 0,   0,   0};
        tbl[2] = '{104, 203, 1, 1, 104, 203};
        tbl[3] = '{120, 203, 1, 1, 108, 203};
        tbl[4] = '{100, 203, 1, 1, 106, 203};
        tbl[5] = '{300, 203, 1, 1, 106, 203};
        tbl[6] = '{110, 205, 1, 1, 107, 203};
        tbl[7] = '{139, 203, 1, 1, 115, 203};
        tbl[8] = '{ 82, 203, 1, 1, 115, 203};
        tbl[9] = '{115, 203, 1, 1, 115, 203};
        for (int i = 10; i < 17; i++) tbl[i] = '{0, 0, 1, 1, 115, 203};
        tbl[17] = '{0, 0, 0, 0, 0, 0};

        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_valid",  int'(bus.oVALID), 0);
        chk("rst_x",      int'(bus.oX), 0);
        chk("rst_y",      int'(bus.oY), 0);
        chk("rst_locked", int'(oLOCKED), 0);
        chk("rst_drop",   int'(oDROP_CNT), 0);
        @(negedge iCLK);
        iRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            pulse(tbl[i].x, tbl[i].y);
            chk($sformatf("tbl%0d_locked", i), int'(oLOCKED), int'(tbl[i].lk));
            @(posedge iCLK);
            #1;
            chk($sformatf("tbl%0d_valid", i), int'(bus.oVALID), int'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d_x", i), int'(bus.oX), tbl[i].ex);
                chk($sformatf("tbl%0d_y", i), int'(bus.oY), tbl[i].ey);
            end
        end

        // Backpressure: two reports while stalled, then accept during a new load
        bus.iREADY = 1'b0;
        pulse(500, 500);
        pulse(500, 500);
        pulse(500, 500);
        pulse(504, 500);
        @(posedge iCLK);
        #1;
        chk("bp_valid", int'(bus.oVALID), 1);
        chk("bp_x",     int'(bus.oX), 501);
        chk("bp_y",     int'(bus.oY), 500);
        chk("bp_drop",  int'(oDROP_CNT), 1);
        repeat (3) @(posedge iCLK);
        #1;
        chk("bp_hold_valid", int'(bus.oVALID), 1);
        chk("bp_hold_x",     int'(bus.oX), 501);
        pulse(505, 500);
        bus.iREADY = 1'b1;
        @(posedge iCLK);
        #1;
        chk("bp3_valid", int'(bus.oVALID), 1);
        chk("bp3_x",     int'(bus.oX), 502);
        chk("bp3_drop",  int'(oDROP_CNT), 1);
        @(posedge iCLK);
        #1;
        chk("bp3_accepted", int'(bus.oVALID), 0);

        // Asynchronous reset in the middle of a cycle with a report pending
        bus.iREADY = 1'b0;
        pulse(503, 500);
        @(posedge iCLK);
        #1;
        chk("pre_arst_valid", int'(bus.oVALID), 1);
        #2;
        iRST = 1'b0;
        #1;
        chk("arst_valid",  int'(bus.oVALID), 0);
        chk("arst_x",      int'(bus.oX), 0);
        chk("arst_y",      int'(bus.oY), 0);
        chk("arst_locked", int'(oLOCKED), 0);
        chk("arst_drop",   int'(oDROP_CNT), 0);
        @(negedge iCLK);
        iRST = 1'b1;
        bus.iREADY = 1'b1;
        pulse(502, 500);
        chk("arst_search_locked", int'(oLOCKED), 0);
        @(posedge iCLK);
        #1;
        chk("arst_search_valid", int'(bus.oVALID), 0);

        // Randomized run against the model, consumer always ready
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        modelReset();
        monEn = 1;
        begin
            int tx, ty, x, y, r, gap;
            tx = 1000; ty = 1000;
            for (int n = 0; n < 400; n++) begin
                tx = tx + $urandom_range(0, 10) - 5;
                ty = ty + $urandom_range(0, 10) - 5;
                if (tx < 100) tx = 100;
                if (tx > 1900) tx = 1900;
                if (ty < 100) ty = 100;
                if (ty > 1900) ty = 1900;
                r = $urandom_range(0, 99);
                if (r < 15) begin
                    x = 0; y = 0;
                end else if (r < 25) begin
                    x = $urandom_range(0, 2047); y = $urandom_range(0, 2047);
                end else begin
                    x = tx + $urandom_range(0, 80) - 40;
                    y = ty + $urandom_range(0, 80) - 40;
                end
                @(negedge iCLK);
                bus.iX = x[W-1:0]; bus.iY = y[W-1:0]; bus.iDVAL = 1'b1;
                modelPulse(x, y);
                @(posedge iCLK);
                #1;
                bus.iDVAL = 1'b0;
                chk("rand_locked", int'(oLOCKED), int'(mLocked));
                gap = $urandom_range(0, 3);
                repeat (gap) @(posedge iCLK);
            end
        end
        repeat (5) @(posedge iCLK);
        #1;
        chk("rand_leftover", expQ.size(), 0);
        chk("rand_drop",     int'(oDROP_CNT), 0);
        monEn = 0;

        // Drop counter saturation under sustained backpressure
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        bus.iREADY = 1'b0;
        for (int n = 0; n < 300; n++) pulse(700, 700);
        repeat (3) @(posedge iCLK);
        #1;
        chk("sat_drop",  int'(oDROP_CNT), 255);
        chk("sat_valid", int'(bus.oVALID), 1);
        chk("sat_x",     int'(bus.oX), 700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
